// File: rtl/rom_fetch_pkg.sv
// rom_fetch_pkg: shared types and default sizes for the ROM fetch controller.
//   state_e : controller states (fetch address/data, hold, halt, debug address/data)
//   ret_e   : state to resume after a debug read
// Debug states are only reachable when ROM_FETCH_DEBUG_EN is defined.
package rom_fetch_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        FETCH_A,
        FETCH_D,
        HOLD,
        HALT,
        DBG_A,
        DBG_D
    } state_e;

    typedef enum logic [1:0] {
        RET_FETCH,
        RET_HOLD,
        RET_HALT
    } ret_e;

endpackage

// File: rtl/rom_fetch_pc.sv
// rom_fetch_pc: next-fetch program counter.
//   i_clk, i_rst   : clock, synchronous active-high reset (loads RESET_PC)
//   i_load         : decoder handshake; advance or jump
//   i_jump         : take i_jump_addr instead of i_pc+1 on load
//   i_jump_addr    : jump target
//   i_pc           : address of the instruction being accepted
//   o_pc_next      : next fetch address, already reflecting a load this cycle
module rom_fetch_pc
    import rom_fetch_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RESET_PC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_addr,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [ADDR_W-1:0] o_pc_next
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    // Increment wraps naturally modulo 2^ADDR_W.
    always_comb begin
        pc_d = pc_q;
        if (i_load) pc_d = i_jump ? i_jump_addr : i_pc + ADDR_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) pc_q <= ADDR_W'(RESET_PC);
        else       pc_q <= pc_d;
    end

    // Exposing the next value lets the ROM address register load it in the
    // same edge as the handshake.
    assign o_pc_next = pc_d;

endmodule

// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: instruction-fetch sequencer and ROM arbiter.
//   i_clk, i_rst              : clock, synchronous active-high reset
//   o_rom_addr, o_rom_enable  : registered ROM address / output enable
//   i_rom_data                : ROM data bus (valid one cycle after address)
//   o_instr, o_pc, o_valid    : instruction register offered to the decoder
//   i_ready                   : decoder accepts o_instr
//   i_jump, i_jump_addr       : redirect next fetch (sampled on handshake)
//   i_halt, o_halted          : stop fetching after this instruction
//   i_dbg_req, i_dbg_addr     : debug read request (level) and address
//   o_dbg_ack, o_dbg_data     : one-cycle ack and held debug read word
// Build option ROM_FETCH_DEBUG_EN: enables the debug read path; otherwise the
// debug inputs are ignored and o_dbg_ack/o_dbg_data read 0.
module rom_fetch_ctrl
    import rom_fetch_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RESET_PC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic              o_rom_enable,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_valid,
    input  logic              i_ready,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_addr,
    input  logic              i_halt,
    output logic              o_halted,
    input  logic              i_dbg_req,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic              o_dbg_ack,
    output logic [DATA_W-1:0] o_dbg_data
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_en_q, rom_en_d;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_next;
    logic              handshake;

    assign handshake = (state_q == HOLD) && i_ready;

    rom_fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (handshake),
        .i_jump      (i_jump),
        .i_jump_addr (i_jump_addr),
        .i_pc        (pc_q),
        .o_pc_next   (pc_next)
    );

`ifdef ROM_FETCH_DEBUG_EN
    ret_e              ret_q, ret_d;
    logic              dbg_ack_q;
    logic [DATA_W-1:0] dbg_data_q;
    logic              dbg_ok;

    // Masking the request during ack keeps a held level from re-granting
    // before the requester has seen its data.
    assign dbg_ok = i_dbg_req && !dbg_ack_q;
`else
    logic unused_dbg;
    assign unused_dbg = ^{i_dbg_req, i_dbg_addr};
`endif

    always_comb begin
        state_d = state_q;
`ifdef ROM_FETCH_DEBUG_EN
        ret_d   = ret_q;
`endif
        case (state_q)
            FETCH_A: state_d = FETCH_D;
            FETCH_D: state_d = HOLD;
            HOLD: begin
                if (handshake) begin
                    if (i_halt) state_d = HALT;
`ifdef ROM_FETCH_DEBUG_EN
                    // Debug wins here, but always returns to a fetch.
                    else if (dbg_ok) begin
                        state_d = DBG_A;
                        ret_d   = RET_FETCH;
                    end
`endif
                    else state_d = FETCH_A;
                end
`ifdef ROM_FETCH_DEBUG_EN
                else if (dbg_ok) begin
                    state_d = DBG_A;
                    ret_d   = RET_HOLD;
                end
`endif
            end
            HALT: begin
`ifdef ROM_FETCH_DEBUG_EN
                if (dbg_ok) begin
                    state_d = DBG_A;
                    ret_d   = RET_HALT;
                end
`endif
            end
`ifdef ROM_FETCH_DEBUG_EN
            DBG_A: state_d = DBG_D;
            DBG_D: begin
                case (ret_q)
                    RET_HOLD: state_d = HOLD;
                    RET_HALT: state_d = HALT;
                    default:  state_d = FETCH_A;
                endcase
            end
`endif
            default: state_d = FETCH_A;
        endcase

        // Address and enable are registered off the next state so the ROM
        // sees them during the matching state.
        rom_addr_d = rom_addr_q;
        if (state_d == FETCH_A) rom_addr_d = pc_next;
`ifdef ROM_FETCH_DEBUG_EN
        if (state_d == DBG_A) rom_addr_d = i_dbg_addr;
`endif
        rom_en_d = (state_d == FETCH_D) || (state_d == DBG_D);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= FETCH_A;
            rom_addr_q <= ADDR_W'(RESET_PC);
            rom_en_q   <= 1'b0;
            instr_q    <= '0;
            pc_q       <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            rom_en_q   <= rom_en_d;
            if (state_q == FETCH_D) begin
                instr_q <= i_rom_data;
                pc_q    <= rom_addr_q;
            end
        end
    end

`ifdef ROM_FETCH_DEBUG_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ret_q      <= RET_FETCH;
            dbg_ack_q  <= 1'b0;
            dbg_data_q <= '0;
        end else begin
            ret_q     <= ret_d;
            dbg_ack_q <= (state_q == DBG_D);
            if (state_q == DBG_D) dbg_data_q <= i_rom_data;
        end
    end

    assign o_dbg_ack  = dbg_ack_q;
    assign o_dbg_data = dbg_data_q;
`else
    assign o_dbg_ack  = 1'b0;
    assign o_dbg_data = '0;
`endif

    assign o_rom_addr   = rom_addr_q;
    assign o_rom_enable = rom_en_q;
    assign o_instr      = instr_q;
    assign o_pc         = pc_q;
    assign o_valid      = (state_q == HOLD);
    assign o_halted     = (state_q == HALT);

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// tb_rom_fetch_ctrl: directed scenarios followed by random stimulus, checked
// every cycle against a cycle-timing model of the fetch/debug protocol.
module tb_rom_fetch_ctrl;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [3:0] o_rom_addr;
    logic       o_rom_enable;
    logic [7:0] rom_bus;
    logic [7:0] o_instr;
    logic [3:0] o_pc;
    logic       o_valid;
    logic       i_ready = 1'b0;
    logic       i_jump = 1'b0;
    logic [3:0] i_jump_addr = '0;
    logic       i_halt = 1'b0;
    logic       o_halted;
    logic       i_dbg_req = 1'b0;
    logic [3:0] i_dbg_addr = '0;
    logic       o_dbg_ack;
    logic [7:0] o_dbg_data;

    int n_chk = 0;
    int n_pass = 0;

`ifdef ROM_FETCH_DEBUG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    always #5 clk = ~clk;

    rom_fetch_ctrl #(.ADDR_W(4), .DATA_W(8), .RESET_PC(0)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .o_rom_addr   (o_rom_addr),
        .o_rom_enable (o_rom_enable),
        .i_rom_data   (rom_bus),
        .o_instr      (o_instr),
        .o_pc         (o_pc),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .i_jump       (i_jump),
        .i_jump_addr  (i_jump_addr),
        .i_halt       (i_halt),
        .o_halted     (o_halted),
        .i_dbg_req    (i_dbg_req),
        .i_dbg_addr   (i_dbg_addr),
        .o_dbg_ack    (o_dbg_ack),
        .o_dbg_data   (o_dbg_data)
    );

    // ROM: registered read, bus driven only while enabled. An undriven bus
    // reads as EE so a capture without enable shows up as wrong data.
    logic [7:0] code [16];
    logic [7:0] rom_q;
    initial for (int i = 0; i < 16; i++) code[i] = 8'(8'hA0 + i);
    always @(posedge clk) rom_q <= code[o_rom_addr];
    assign rom_bus = o_rom_enable ? rom_q : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    // Reference model: cycle numbers relative to the first cycle after reset.
    // Tracks when the next instruction must appear, which address it comes
    // from, when debug acks land and which cycles carry a ROM enable.
    initial begin : monitor
        bit         rst_prev = 1'b1;
        int         cyc = 0, valid_at = 2, halt_at = 0;
        int         ack_at = -10, dbg_en_at = -10, busy_lo = -10, busy_hi = -10;
        bit         halted_m = 1'b0;
        int         exp_pc = 0;
        logic [7:0] exp_dbg = 0, last_dbg = 0;
        bit         ev, eh, een, grant_ok;
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                chk("rst_valid", o_valid, 0);
                chk("rst_en", o_rom_enable, 0);
                chk("rst_halted", o_halted, 0);
                chk("rst_ack", o_dbg_ack, 0);
                chk("rst_dbg_data", o_dbg_data, 0);
                chk("rst_instr", o_instr, 0);
                chk("rst_pc", o_pc, 0);
                cyc = 0; valid_at = 2; halted_m = 0; halt_at = 0;
                ack_at = -10; dbg_en_at = -10; busy_lo = -10; busy_hi = -10;
                exp_pc = 0; last_dbg = 0;
            end else begin
                cyc++;
                ev  = !halted_m && cyc >= valid_at;
                eh  = halted_m && cyc >= halt_at && !(cyc >= busy_lo && cyc <= busy_hi);
                een = (!halted_m && cyc == valid_at - 1) || cyc == dbg_en_at;
                chk("valid", o_valid, ev);
                chk("halted", o_halted, eh);
                chk("rom_enable", o_rom_enable, een);
                chk("dbg_ack", o_dbg_ack, cyc == ack_at);
                if (cyc == ack_at) last_dbg = exp_dbg;
                chk("dbg_data", o_dbg_data, last_dbg);
                if (ev) begin
                    chk("instr", o_instr, code[exp_pc]);
                    chk("pc", o_pc, exp_pc);
                end
                grant_ok = DBG && i_dbg_req && cyc != ack_at;
                if (ev && i_ready) begin
                    exp_pc = i_jump ? int'(i_jump_addr) : (exp_pc + 1) % 16;
                    if (i_halt) begin
                        halted_m = 1; halt_at = cyc + 1;
                    end else if (grant_ok) begin
                        exp_dbg = code[i_dbg_addr]; ack_at = cyc + 3; dbg_en_at = cyc + 2;
                        valid_at = cyc + 5;
                    end else begin
                        valid_at = cyc + 3;
                    end
                end else if ((ev || eh) && grant_ok) begin
                    exp_dbg = code[i_dbg_addr]; ack_at = cyc + 3; dbg_en_at = cyc + 2;
                    if (ev) valid_at = cyc + 3;
                    else begin busy_lo = cyc + 1; busy_hi = cyc + 2; end
                end
            end
            rst_prev = i_rst;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        step();
        i_rst = 1'b1; i_ready = 0; i_jump = 0; i_halt = 0; i_dbg_req = 0;
        step(); step();
        i_rst = 1'b0;
    endtask

    // Pulses ready one instruction at a time until `target` is on offer;
    // returns at the negedge of a HOLD cycle with i_ready low.
    task automatic advance_to(input int target);
        int n = 0;
        i_ready = 1'b0;
        while (1) begin
            @(negedge clk);
            n++;
            if (o_valid && int'(o_pc) == target) break;
            if (n > 200) begin
                chk("advance_to", o_valid && int'(o_pc) == target, 1);
                break;
            end
            if (o_valid) begin
                step(); i_ready = 1'b1;
                step(); i_ready = 1'b0;
            end
        end
    endtask

    initial begin : stim
        int hcnt = 0;
        int n = 0;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;

        // Full-rate fetch through the wrap.
        i_ready = 1'b1;
        repeat (60) step();

        // Stall at pc 3, then release.
        do_reset();
        advance_to(3);
        repeat (10) step();
        i_ready = 1'b1;
        repeat (8) step();

        // Jump without handshake is ignored; jump with handshake taken.
        advance_to(5);
        step(); i_jump = 1'b1; i_jump_addr = 4'd0;
        repeat (3) step();
        i_jump_addr = 4'd12; i_ready = 1'b1;
        step(); i_jump = 1'b0; i_ready = 1'b0;
        advance_to(12);

        // Halt at pc 7, then a debug read while halted.
        advance_to(7);
        step(); i_halt = 1'b1; i_ready = 1'b1;
        step(); i_halt = 1'b0; i_ready = 1'b0;
        repeat (4) step();
        i_dbg_req = 1'b1; i_dbg_addr = 4'd2;
        step(); i_dbg_req = 1'b0;
        repeat (6) step();

        // Held debug request while stalled in HOLD.
        do_reset();
        advance_to(1);
        step(); i_dbg_req = 1'b1; i_dbg_addr = 4'd9;
        repeat (20) step();
`ifdef ROM_FETCH_DEBUG_EN
        // Reset lands on the DBG_D of the following grant: no ack may appear.
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (o_dbg_ack) break;
            if (n > 20) begin chk("wait_ack", o_dbg_ack, 1); break; end
        end
        step(); step(); step();
        i_rst = 1'b1; i_dbg_req = 1'b0;
        step(); step();
        i_rst = 1'b0;
        repeat (10) step();
`endif
        i_dbg_req = 1'b0;

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            step();
            i_ready     = ($urandom_range(0, 3) != 0);
            i_jump      = ($urandom_range(0, 3) == 0);
            i_jump_addr = 4'($urandom);
            i_halt      = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 5) == 0) i_dbg_req = ~i_dbg_req;
            i_dbg_addr  = 4'($urandom);
            if (o_halted) hcnt++;
            if (hcnt > 6 || $urandom_range(0, 299) == 0) begin
                hcnt = 0;
                do_reset();
            end
        end
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rom_fetch_ctrl.md
# rom_fetch_ctrl

Instruction-fetch sequencer and arbiter for the 16x8 program ROM, whose registered read has one-cycle latency and whose output bus is tri-stated by an enable. Owns the program counter, drives the ROM address and enable, captures each instruction into an instruction register and offers it to the decoder over a valid/ready handshake. Shares the ROM with an optional debug/monitor read port.

## Interface
- ADDR_W, 4, ROM address width; PC wraps modulo 2^ADDR_W
- DATA_W, 8, ROM word / instruction width
- RESET_PC, 0, first fetch address after reset
- i_clk  in  1  clock; every register updates on its rising edge
- i_rst  in  1  reset, synchronous, active-high
- o_rom_addr  out  ADDR_W  registered address to ROM i_addr
- o_rom_enable  out  1  registered; drives ROM i_enable
- i_rom_data  in  DATA_W  ROM o_instr bus
- o_instr  out  DATA_W  instruction register
- o_pc  out  ADDR_W  address o_instr was fetched from
- o_valid  out  1  o_instr is offered to the decoder
- i_ready  in  1  decoder accepts o_instr
- i_jump  in  1  next fetch goes to i_jump_addr; sampled only on handshake
- i_jump_addr  in  ADDR_W  jump target
- i_halt  in  1  stop fetching after this instruction; sampled only on handshake
- o_halted  out  1  fetch halted
- i_dbg_req  in  1  debug read request, level
- i_dbg_addr  in  ADDR_W  debug read address, latched at grant
- o_dbg_ack  out  1  one-cycle pulse; o_dbg_data valid
- o_dbg_data  out  DATA_W  last debug read word, held

## Operation
- States: FETCH_A, FETCH_D, HOLD, HALT, DBG_A, DBG_D; a 2-bit return register (FETCH_A, HOLD, HALT).
- FETCH_A: o_rom_addr = pc_next → FETCH_D.
- FETCH_D: o_rom_enable=1; capture o_instr=i_rom_data, o_pc=o_rom_addr → HOLD.
- HOLD: o_valid=1. Handshake (o_valid & i_ready) has priority: pc_next = i_jump ? i_jump_addr : o_pc+1 (15+1 wraps to 0); next state HALT if i_halt, else DBG_A (ret FETCH_A) if i_dbg_req, else FETCH_A. Without handshake: i_dbg_req → DBG_A (ret HOLD), o_instr kept.
- HALT: o_halted=1; only i_rst leaves. i_dbg_req → DBG_A (ret HALT).
- DBG_A: o_rom_addr = latched i_dbg_addr → DBG_D. DBG_D: o_rom_enable=1, capture o_dbg_data → ret; o_dbg_ack=1 the next cycle.
- o_valid is 1 only in HOLD; i_ready is ignored elsewhere.
- i_dbg_req is ignored in the cycle o_dbg_ack=1, so a held request never double-grants.
- Fairness: a debug access after a handshake is followed unconditionally by a fetch; a pending fetch never blocks debug for more than one fetch.
- o_rom_enable=0 in all states except FETCH_D and DBG_D; the ROM never drives the bus otherwise.
- Reset (any state, mid-access included): state FETCH_A, pc_next=o_rom_addr=RESET_PC, o_instr=0, o_pc=0, o_valid=0, o_rom_enable=0, o_halted=0, o_dbg_ack=0, o_dbg_data=0; any in-flight access is dropped.

## Timing
- Cycles counted from the first with i_rst=0: C0 FETCH_A, C1 FETCH_D, C2 o_valid=1 with code[RESET_PC].
- Handshake in cycle H → o_valid=0 in H+1 and H+2; next instruction valid in H+3. Peak rate: 1 instruction per 3 cycles.
- Debug request in HOLD at cycle H without ready → DBG_A H+1, DBG_D H+2, o_dbg_ack and o_dbg_data in H+3, o_valid=1 again in H+3 with unchanged o_instr.
- Handshake with i_halt in H → o_halted=1 from H+1.

## Configuration
- ROM_FETCH_DEBUG_EN defined: debug port and DBG states as above.
- Undefined: DBG states are not built; i_dbg_req and i_dbg_addr are ignored; o_dbg_ack=0 and o_dbg_data=0 constantly; port list unchanged.

## Structure
- Package rom_fetch_pkg: state enum, return-state enum, default ADDR_W/DATA_W constants.
- Sub-module rom_fetch_pc: pc_next register with load (reset/jump), increment and wrap.

## Test plan
- ROM code[i]=8'hA0+i, i_ready=1: after reset o_instr=A0,A1,…,AF,A0 with o_pc wrapping 15→0; o_valid high every 3rd cycle.
- i_ready=0 for 10 cycles at o_pc=3: o_instr=A3 and o_valid=1 held, no ROM enable pulses; then ready → A4 three cycles later.
- Handshake at o_pc=5 with i_jump=1, i_jump_addr=12 → next o_instr=AC, o_pc=12; i_jump without handshake has no effect.
- Handshake at o_pc=7 with i_halt=1 → o_halted=1 next cycle, o_valid stays 0; debug read addr 2 in HALT → o_dbg_data=A2, ack one cycle.
- i_dbg_req held high with addr 9 while stalled in HOLD → ack every 4 cycles with A9, o_instr unchanged; i_rst asserted during DBG_D → no ack, restart at RESET_PC.
- Build without ROM_FETCH_DEBUG_EN: i_dbg_req=1 constantly → o_dbg_ack never asserts, fetch sequence identical to the first scenario.
